// File: rtl/u2_to_onehot_encoder_pkg.sv
// Shared definitions for the U2 to one-hot encoder: buffer states and the
// packed layout of an encoded word {vector, ovf, err}.
package u2_to_onehot_encoder_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  localparam int FLAG_ERR_BIT = 0;
  localparam int FLAG_OVF_BIT = 1;
  localparam int VEC_LSB      = 2;

endpackage

// File: rtl/u2_to_onehot_encoder_core.sv
// Combinational encoder: signed position code -> packed {vector, ovf, err}.
// Negative codes raise err, codes past the vector raise ovf; vector is zero then.
module onehot_enc_core
  import u2_to_onehot_encoder_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0]         i_y_u2,
  output logic [2*LEN+VEC_LSB-1:0] o_word
);

  logic signed [31:0] v_s;

  // Sign-extend so the range checks are done on the true signed value.
  assign v_s = {{(32-WIDTH){i_y_u2[WIDTH-1]}}, i_y_u2};

  always_comb begin
    o_word = '0;
    if (v_s < 0) begin
      o_word[FLAG_ERR_BIT] = 1'b1;
    end else if (v_s >= 2*LEN) begin
      o_word[FLAG_OVF_BIT] = 1'b1;
    end else begin
      for (int k = 0; k < 2*LEN; k++) begin
        o_word[VEC_LSB+k] = (v_s == k);
      end
    end
  end

endmodule

// File: rtl/u2_to_onehot_encoder.sv
// U2 code to one-hot {B,A} encoder with a 2-entry output buffer so that
// o_ready is registered and never depends combinationally on i_ready.
module u2_to_onehot_encoder
  import u2_to_onehot_encoder_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_y_u2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LEN-1:0]   o_a_oh,
  output logic [LEN-1:0]   o_b_oh,
  output logic             o_overflow,
  output logic             o_err
);

  localparam int WORD_W = 2*LEN + VEC_LSB;

  logic [WORD_W-1:0] enc_word;
  logic [WORD_W-1:0] head_q;
  logic [WORD_W-1:0] tail_q;
  buf_state_e        state_q;
  logic              valid_q;
  logic              ready_q;
  logic              push;
  logic              pop;

  onehot_enc_core #(
    .LEN   (LEN),
    .WIDTH (WIDTH)
  ) u_core (
    .i_y_u2 (i_y_u2),
    .o_word (enc_word)
  );

  assign push = i_valid & ready_q;
  assign pop  = valid_q & i_ready;

  // head_q is the presented word; tail_q holds the word absorbed under back-pressure.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_q  <= enc_word;
            state_q <= ST_ONE;
            valid_q <= 1'b1;
          end else begin
            head_q  <= '0;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_q  <= enc_word;
          end else if (push) begin
            tail_q  <= enc_word;
            state_q <= ST_FULL;
            ready_q <= 1'b0;
          end else if (pop) begin
            head_q  <= '0;
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
          end else begin
            head_q  <= head_q;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_q  <= tail_q;
            state_q <= ST_ONE;
            ready_q <= 1'b1;
          end else begin
            head_q  <= head_q;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          head_q  <= '0;
          tail_q  <= '0;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_valid    = valid_q;
  assign o_ready    = ready_q;
  assign o_a_oh     = head_q[VEC_LSB +: LEN];
  assign o_b_oh     = head_q[VEC_LSB+LEN +: LEN];
  assign o_overflow = head_q[FLAG_OVF_BIT];
  assign o_err      = head_q[FLAG_ERR_BIT];

endmodule

// File: tb/tb_u2_to_onehot_encoder.sv
// Self-checking bench: constant vector table, hand sequences for buffering and
// reset, and random traffic against a queue-based reference model.
module tb_u2_to_onehot_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, ovf, err;
  logic [4:0] code;
  logic [7:0] a_oh, b_oh;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, ovf4, err4;
  logic [4:0] code4;
  logic [3:0] a_oh4, b_oh4;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ovf;
    logic       err;
  } exp_t;

  typedef struct {
    logic [4:0] code;
    exp_t       exp;
  } vec_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  u2_to_onehot_encoder #(.LEN(8), .WIDTH(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(out_ready),
    .i_y_u2(code), .o_valid(out_valid), .i_ready(in_ready),
    .o_a_oh(a_oh), .o_b_oh(b_oh), .o_overflow(ovf), .o_err(err)
  );

  u2_to_onehot_encoder #(.LEN(4), .WIDTH(5)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid4), .o_ready(out_ready4),
    .i_y_u2(code4), .o_valid(out_valid4), .i_ready(in_ready4),
    .o_a_oh(a_oh4), .o_b_oh(b_oh4), .o_overflow(ovf4), .o_err(err4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: the code's signed value selects one bit of a 2*len vector.
  function automatic logic [17:0] model(input logic [4:0] c, input int len);
    int v;
    logic [15:0] vec;
    v   = $signed(c);
    vec = 16'h0000;
    if (v < 0) return {16'h0000, 1'b0, 1'b1};
    if (v >= 2*len) return {16'h0000, 1'b1, 1'b0};
    vec[v] = 1'b1;
    return {vec, 1'b0, 1'b0};
  endfunction

  function automatic exp_t model8(input logic [4:0] c);
    logic [17:0] r;
    r = model(c, 8);
    return '{a: r[9:2], b: r[17:10], ovf: r[1], err: r[0]};
  endfunction

  // One clock of the 8-bit DUT: check against the model's queue, then advance.
  task automatic cycle();
    logic exp_valid, exp_ready, do_pop, do_push, was_rst;
    exp_t e;
    exp_valid = (exp_q.size() != 0);
    exp_ready = (exp_q.size() < 2);
    chk("o_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    chk("o_ready", {31'd0, out_ready}, {31'd0, exp_ready});
    e = exp_valid ? exp_q[0] : exp_t'(18'd0);
    chk("word", {14'd0, a_oh, b_oh, ovf, err}, {14'd0, e});
    do_pop  = exp_valid & in_ready;
    do_push = exp_ready & in_valid;
    e       = model8(code);
    was_rst = rst;
    @(posedge clk);
    #1;
    if (was_rst) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(e);
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{5'd0,  '{8'h01, 8'h00, 1'b0, 1'b0}};
    tbl[1] = '{5'd7,  '{8'h80, 8'h00, 1'b0, 1'b0}};
    tbl[2] = '{5'd8,  '{8'h00, 8'h01, 1'b0, 1'b0}};
    tbl[3] = '{5'd15, '{8'h00, 8'h80, 1'b0, 1'b0}};
    tbl[4] = '{5'h1F, '{8'h00, 8'h00, 1'b0, 1'b1}};
    tbl[5] = '{5'h10, '{8'h00, 8'h00, 1'b0, 1'b1}};
    tbl[6] = '{5'd3,  '{8'h08, 8'h00, 1'b0, 1'b0}};
    tbl[7] = '{5'd12, '{8'h00, 8'h10, 1'b0, 1'b0}};

    rst = 1'b1; in_valid = 1'b0; in_ready = 1'b1; code = 5'd0;
    in_valid4 = 1'b0; in_ready4 = 1'b1; code4 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, out_ready}, 32'd1);
    chk("rst_word", {14'd0, a_oh, b_oh, ovf, err}, 32'd0);

    // Table: each code appears one cycle after its push.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; code = tbl[i].code;
      cycle();
      chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("tbl%0d_word", i), {14'd0, a_oh, b_oh, ovf, err}, {14'd0, tbl[i].exp});
      in_valid = 1'b0;
      cycle();
    end

    // Overflow on the LEN=4 instance.
    code4 = 5'd8; in_valid4 = 1'b1;
    @(posedge clk); #1;
    chk("l4_ovf8", {26'd0, a_oh4, b_oh4, ovf4, err4}, {26'd0, 4'h0, 4'h0, 1'b1, 1'b0});
    code4 = 5'd7;
    @(posedge clk); #1;
    chk("l4_code7", {26'd0, a_oh4, b_oh4, ovf4, err4}, {26'd0, 4'h0, 4'h8, 1'b0, 1'b0});
    code4 = 5'd15;
    @(posedge clk); #1;
    chk("l4_ovf15", {26'd0, a_oh4, b_oh4, ovf4, err4}, {26'd0, 4'h0, 4'h0, 1'b1, 1'b0});
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    chk("l4_empty", {30'd0, out_valid4, out_ready4}, 32'd1);

    // Back-pressure: fill to FULL, offer a word that must be ignored, then drain.
    in_ready = 1'b0; in_valid = 1'b1; code = 5'd3;
    cycle();
    code = 5'd5;
    cycle();
    chk("bp_full_ready", {31'd0, out_ready}, 32'd0);
    chk("bp_hold_a", {24'd0, a_oh}, 32'h08);
    code = 5'd9;
    cycle();
    in_valid = 1'b0; in_ready = 1'b1;
    cycle();
    chk("bp_second_a", {24'd0, a_oh}, 32'h20);
    cycle();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Streaming: one word per cycle with o_ready held high.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; code = 5'(i);
      cycle();
      chk($sformatf("stream%0d_ready", i), {31'd0, out_ready}, 32'd1);
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // Reset while FULL discards the buffered words.
    in_ready = 1'b0; in_valid = 1'b1; code = 5'd1;
    cycle();
    code = 5'd2;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, out_ready}, 32'd1);
    chk("mid_rst_word", {14'd0, a_oh, b_oh, ovf, err}, 32'd0);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_ready = ($urandom_range(0, 3) != 0);
      code     = 5'($urandom);
      cycle();
    end
    in_valid = 1'b0; in_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
